// File: rtl/sparsity_adaptive_fsm.sv
// Windowed activation-density monitor choosing a structured-sparsity mode
// (dense, 2:4, 1:4, 1:8) with thresholds, hysteresis and a minimum hold time.
module sparsity_adaptive_fsm #(
  parameter int WINDOW_SIZE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] nonzero_count,
  input  logic [15:0] total_count,
  input  logic        manual_override_mode,
  input  logic [1:0]  manual_mode_select,
  input  logic [9:0]  thresh_2to4,
  input  logic [9:0]  thresh_1to4,
  input  logic [9:0]  thresh_1to8,
  input  logic [9:0]  hyst_milli,
  input  logic [7:0]  min_hold_windows,
  input  logic [15:0] util_milli_pct,
  output logic [1:0]  current_mode,
  output logic        mode_change_pulse,
  output logic [15:0] last_density_milli,
  output logic        window_complete,
  output logic [15:0] change_count,
  output logic [15:0] mode_eff_milli
);

  typedef enum logic [1:0] {
    MODE_DENSE = 2'd0,
    MODE_2TO4  = 2'd1,
    MODE_1TO4  = 2'd2,
    MODE_1TO8  = 2'd3
  } mode_t;

  localparam logic [7:0] LAST_IDX = 8'(WINDOW_SIZE - 1);

  mode_t       mode_q, mode_d;
  logic [31:0] acc_nz, acc_tot, win_nz, win_tot;
  logic [7:0]  sample_cnt;
  logic [7:0]  hold_q, hold_d, hold_next;
  logic        close_pending;
  logic        change;
  logic [41:0] scaled, divisor, quotient;
  logic [15:0] density;
  logic [1:0]  raw;
  logic [9:0]  lower_thr, upper_thr, lower_lim;
  logic [10:0] upper_lim;
  logic        sparser_ok, denser_ok, hold_ok;
  logic        unused_util;

  assign unused_util  = ^util_milli_pct;
  assign current_mode = mode_q;

  // The closing sample's totals are snapshotted so the accumulators are free
  // for the next window in the close cycle (back-to-back windows).
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_nz        <= '0;
      acc_tot       <= '0;
      win_nz        <= '0;
      win_tot       <= '0;
      sample_cnt    <= '0;
      close_pending <= 1'b0;
    end else begin
      close_pending <= 1'b0;
      if (sample_valid) begin
        if (sample_cnt == LAST_IDX) begin
          win_nz        <= acc_nz + {16'd0, nonzero_count};
          win_tot       <= acc_tot + {16'd0, total_count};
          acc_nz        <= '0;
          acc_tot       <= '0;
          sample_cnt    <= '0;
          close_pending <= 1'b1;
        end else begin
          acc_nz     <= acc_nz + {16'd0, nonzero_count};
          acc_tot    <= acc_tot + {16'd0, total_count};
          sample_cnt <= sample_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    divisor  = (win_tot == 32'd0) ? 42'd1 : {10'd0, win_tot};
    scaled   = {10'd0, win_nz} * 42'd1000;
    quotient = scaled / divisor;
    if (win_tot == 32'd0 || quotient > 42'd1000) density = 16'd1000;
    else                                         density = quotient[15:0];
  end

  always_comb begin
    if (density >= {6'd0, thresh_2to4})      raw = 2'd0;
    else if (density >= {6'd0, thresh_1to4}) raw = 2'd1;
    else if (density >= {6'd0, thresh_1to8}) raw = 2'd2;
    else                                     raw = 2'd3;
  end

  // Thresholds bounding the current mode from the dense and the sparse side.
  always_comb begin
    lower_thr = '0;
    upper_thr = '0;
    case (mode_q)
      MODE_DENSE: lower_thr = thresh_2to4;
      MODE_2TO4: begin lower_thr = thresh_1to4; upper_thr = thresh_2to4; end
      MODE_1TO4: begin lower_thr = thresh_1to8; upper_thr = thresh_1to4; end
      MODE_1TO8: upper_thr = thresh_1to8;
      default: ;
    endcase
    lower_lim  = (lower_thr >= hyst_milli) ? (lower_thr - hyst_milli) : 10'd0;
    upper_lim  = {1'b0, upper_thr} + {1'b0, hyst_milli};
    sparser_ok = (raw > mode_q) && (density <= {6'd0, lower_lim});
    denser_ok  = (raw < mode_q) && (density >= {5'd0, upper_lim});
    hold_next  = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
    hold_ok    = hold_next >= min_hold_windows;
  end

  always_comb begin
    mode_d = mode_q;
    hold_d = hold_q;
    if (manual_override_mode) begin
      mode_d = mode_t'(manual_mode_select);
      if (close_pending) hold_d = hold_next;
      if (mode_d != mode_q) hold_d = 8'd0;
    end else if (close_pending) begin
      hold_d = hold_next;
      if (hold_ok && (sparser_ok || denser_ok)) begin
        mode_d = mode_t'(raw);
        hold_d = 8'd0;
      end
    end
    change = (mode_d != mode_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q             <= MODE_DENSE;
      hold_q             <= '0;
      mode_change_pulse  <= 1'b0;
      window_complete    <= 1'b0;
      last_density_milli <= '0;
      change_count       <= '0;
    end else begin
      mode_q            <= mode_d;
      hold_q            <= hold_d;
      mode_change_pulse <= change;
      window_complete   <= close_pending;
      if (close_pending) last_density_milli <= density;
      if (change && change_count != 16'hFFFF) change_count <= change_count + 16'd1;
    end
  end

  always_comb begin
    case (mode_q)
      MODE_DENSE: mode_eff_milli = 16'd1000;
      MODE_2TO4:  mode_eff_milli = 16'd600;
      MODE_1TO4:  mode_eff_milli = 16'd350;
      default:    mode_eff_milli = 16'd200;
    endcase
  end

endmodule

// File: tb/tb_sparsity_adaptive_fsm.sv
// Scoreboard bench for sparsity_adaptive_fsm: a reference model predicts each
// window's density/mode/change state when the window's last sample is driven.
module tb_sparsity_adaptive_fsm;

  localparam int W = 35;  // {pulse, change_count[15:0], mode[1:0], density[15:0]}

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] nonzero_count, total_count;
  logic        manual_override_mode;
  logic [1:0]  manual_mode_select;
  logic [9:0]  thresh_2to4, thresh_1to4, thresh_1to8, hyst_milli;
  logic [7:0]  min_hold_windows;
  logic [15:0] util_milli_pct;
  logic [1:0]  current_mode;
  logic        mode_change_pulse;
  logic [15:0] last_density_milli;
  logic        window_complete;
  logic [15:0] change_count;
  logic [15:0] mode_eff_milli;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int pulse_seen = 0;
  int pulse_base = 0;
  int m_mode, m_hold, m_changes;

  sparsity_adaptive_fsm #(.WINDOW_SIZE(8)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .nonzero_count(nonzero_count), .total_count(total_count),
    .manual_override_mode(manual_override_mode), .manual_mode_select(manual_mode_select),
    .thresh_2to4(thresh_2to4), .thresh_1to4(thresh_1to4), .thresh_1to8(thresh_1to8),
    .hyst_milli(hyst_milli), .min_hold_windows(min_hold_windows),
    .util_milli_pct(util_milli_pct), .current_mode(current_mode),
    .mode_change_pulse(mode_change_pulse), .last_density_milli(last_density_milli),
    .window_complete(window_complete), .change_count(change_count),
    .mode_eff_milli(mode_eff_milli)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int eff_of(input int m);
    case (m)
      0: return 1000;
      1: return 600;
      2: return 350;
      default: return 200;
    endcase
  endfunction

  function automatic int thr_of(input int i);
    case (i)
      0: return int'(thresh_2to4);
      1: return int'(thresh_1to4);
      default: return int'(thresh_1to8);
    endcase
  endfunction

  // Reference model of one window close.
  task automatic model_close(input longint nzs, input longint tots);
    longint d;
    int raw, lim, hn;
    bit ok, pulse;
    if (tots == 0) d = 1000;
    else begin
      d = (nzs * 1000) / tots;
      if (d > 1000) d = 1000;
    end
    if (d >= thr_of(0))      raw = 0;
    else if (d >= thr_of(1)) raw = 1;
    else if (d >= thr_of(2)) raw = 2;
    else                     raw = 3;
    ok = 1'b0;
    if (raw > m_mode) begin
      lim = thr_of(m_mode) - int'(hyst_milli);
      if (lim < 0) lim = 0;
      ok = (d <= lim);
    end else if (raw < m_mode) begin
      lim = thr_of(m_mode - 1) + int'(hyst_milli);
      ok = (d >= lim);
    end
    hn = (m_hold >= 255) ? 255 : m_hold + 1;
    pulse = 1'b0;
    if (ok && hn >= int'(min_hold_windows)) begin
      m_mode = raw; m_hold = 0; m_changes++; pulse = 1'b1;
    end else begin
      m_hold = hn;
    end
    exp_q.push_back({pulse, 16'(m_changes), 2'(m_mode), 16'(d)});
  endtask

  // Driver tasks: all start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_sample(input logic [15:0] nz, input logic [15:0] tot);
    sample_valid = 1'b1; nonzero_count = nz; total_count = tot;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_window(input int nz, input int tot, input bit rnd);
    longint nzs = 0, tots = 0;
    int a, b;
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 1));
      if (rnd) begin b = $urandom_range(0, 200); a = $urandom_range(0, b); end
      else begin a = nz; b = tot; end
      nzs += a; tots += b;
      if (i == 7) model_close(nzs, tots);
      drive_sample(16'(a), 16'(b));
    end
  endtask

  task automatic send_partial(input int n, input int nz, input int tot);
    for (int i = 0; i < n; i++) drive_sample(16'(nz), 16'(tot));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b1; nonzero_count = 16'd50; total_count = 16'd100;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; sample_valid = 1'b0;
    m_mode = 0; m_hold = 0; m_changes = 0;
    exp_q.delete();
    pulse_base = pulse_seen;
    @(negedge clk);
    check_eq("rst_mode", 32'(current_mode), 0);
    check_eq("rst_pulse", 32'(mode_change_pulse), 0);
    check_eq("rst_density", 32'(last_density_milli), 0);
    check_eq("rst_wc", 32'(window_complete), 0);
    check_eq("rst_count", 32'(change_count), 0);
    check_eq("rst_eff", 32'(mode_eff_milli), 1000);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    check_eq("drain", 32'(exp_q.size()), 0);
    check_eq("pulse_total", 32'(pulse_seen - pulse_base), 32'(m_changes));
    check_eq("count_total", 32'(change_count), 32'(m_changes));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (mode_change_pulse) pulse_seen++;
      if (window_complete) begin
        check_eq("window_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("density", 32'(last_density_milli), 32'(e[15:0]));
          check_eq("mode", 32'(current_mode), 32'(e[17:16]));
          check_eq("change_count", 32'(change_count), 32'(e[33:18]));
          check_eq("pulse", 32'(mode_change_pulse), 32'(e[34]));
          check_eq("eff", 32'(mode_eff_milli), 32'(eff_of(int'(e[17:16]))));
        end
      end
    end
  end

  initial begin
    manual_override_mode = 1'b0; manual_mode_select = 2'd0;
    thresh_2to4 = 10'd700; thresh_1to4 = 10'd400; thresh_1to8 = 10'd150;
    hyst_milli = 10'd50; min_hold_windows = 8'd1;
    util_milli_pct = 16'd1234;
    nonzero_count = '0; total_count = '0; sample_valid = 1'b0;
    do_reset();

    // Density sweep through every mode and back to dense.
    send_window(80, 100, 0);
    send_window(50, 100, 0);
    send_window(30, 100, 0);
    send_window(10, 100, 0);
    send_window(85, 100, 0);
    drain();

    // Hysteresis: enter 2:4, then densities short of and past the margin.
    send_window(50, 100, 0);
    send_window(68, 100, 0);
    send_window(72, 100, 0);
    send_window(76, 100, 0);
    drain();

    // Minimum hold of 3 windows after the last change.
    min_hold_windows = 8'd3;
    send_window(30, 100, 0);
    send_window(30, 100, 0);
    send_window(30, 100, 0);
    drain();

    // Manual override to 1:8, then release and let a dense window pull back.
    manual_override_mode = 1'b1; manual_mode_select = 2'd3;
    @(posedge clk); @(negedge clk);
    m_mode = 3; m_hold = 0; m_changes++;
    check_eq("manual_mode", 32'(current_mode), 3);
    check_eq("manual_pulse", 32'(mode_change_pulse), 1);
    check_eq("manual_eff", 32'(mode_eff_milli), 200);
    @(posedge clk); #1;
    check_eq("manual_count", 32'(change_count), 32'(m_changes));
    manual_override_mode = 1'b0;
    min_hold_windows = 8'd1;
    idle(2);
    check_eq("manual_hold_mode", 32'(current_mode), 3);
    send_window(90, 100, 0);
    drain();

    // Empty-total window, over-unity clamp, and random windows.
    send_window(0, 0, 0);
    send_window(200, 100, 0);
    for (int k = 0; k < 6; k++) send_window(0, 0, 1);
    drain();

    // Reset mid-window with sample_valid held high through reset.
    send_partial(4, 10, 100);
    do_reset();
    send_partial(7, 90, 100);
    idle(4);
    check_eq("no_early_close", 32'(exp_q.size()), 0);
    model_close(longint'(7 * 90 + 90), longint'(8 * 100));
    drive_sample(16'd90, 16'd100);
    send_window(30, 100, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", n_checks, -1);
    $fatal(1);
  end

endmodule

// File: doc/sparsity_adaptive_fsm.md
Name: sparsity_adaptive_fsm

Overview:
Windowed activation-density monitor that selects a structured-sparsity execution mode (dense, 2:4, 1:4, 1:8) using programmable thresholds, hysteresis and a minimum hold time. It sits beside the PE array and power manager. It reports the selected mode, the last window density, and a relative dynamic-power/throughput efficiency factor for downstream power and throughput scaling.

Parameters:
WINDOW_SIZE, 8, number of accepted samples per evaluation window (range 1..255)

Ports:
clk  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
sample_valid  in  1  qualifies one sample this cycle
nonzero_count  in  16  nonzero elements in sample
total_count  in  16  total elements in sample
manual_override_mode  in  1  1 = mode forced from manual_mode_select
manual_mode_select  in  2  forced mode code
thresh_2to4  in  10  density (milli) boundary dense/2:4
thresh_1to4  in  10  boundary 2:4/1:4
thresh_1to8  in  10  boundary 1:4/1:8
hyst_milli  in  10  hysteresis margin (milli)
min_hold_windows  in  8  minimum completed windows in a mode before auto change
util_milli_pct  in  16  utilization hint; reserved, no functional effect
current_mode  out  2  0=dense,1=2:4,2=1:4,3=1:8
mode_change_pulse  out  1  one-cycle pulse when current_mode changes
last_density_milli  out  16  density of last completed window, 0..1000
window_complete  out  1  one-cycle pulse per completed window
change_count  out  16  saturating count of mode changes
mode_eff_milli  out  16  efficiency factor of current_mode

Behaviour:
- Reset values: current_mode=0, mode_change_pulse=0, last_density_milli=0, window_complete=0, change_count=0. Accumulators, sample counter and hold counter are 0. Reset mid-window discards the partial window.
- Accumulation: on each cycle with sample_valid=1, add nonzero_count and total_count into 32-bit accumulators and increment the sample counter. Cycles with sample_valid=0 are ignored.
- When the WINDOW_SIZE-th sample is accepted, the window closes. On the next rising edge (1-cycle latency):
  - window_complete=1 for exactly one cycle.
  - last_density_milli = floor(nz_acc*1000/tot_acc), clamped to 1000. If tot_acc=0, density=1000.
  - Accumulators and sample counter clear.
- Back-to-back windows are supported with no idle cycles. A sample arriving in the close cycle belongs to the next window.
- Classification of density D (raw target):
  - D>=thresh_2to4 → 0
  - else D>=thresh_1to4 → 1
  - else D>=thresh_1to8 → 2
  - else → 3
- Hysteresis gating (automatic mode only, evaluated at window close):
  - Sparser move allowed only if D <= lower_thresh(current) - hyst, where lower_thresh is thresh_2to4, thresh_1to4, thresh_1to8 for modes 0, 1, 2. The subtraction saturates at 0.
  - Denser move allowed only if D >= upper_thresh(current) + hyst, where upper_thresh is thresh_2to4, thresh_1to4, thresh_1to8 for modes 1, 2, 3.
  - When allowed, new mode = raw target. Multi-step jumps are permitted.
- Hold counter:
  - At each window close, hold_next = sat8(hold+1).
  - A change is permitted only if hold_next >= min_hold_windows; min_hold_windows of 0 or 1 means no restriction.
  - On a change, hold is set to 0; otherwise hold = hold_next.
- Mode update timing: current_mode, mode_change_pulse and change_count (saturating at 0xFFFF) update on the same edge as window_complete.
- Manual override: while manual_override_mode=1, current_mode <= manual_mode_select every cycle, with 1-cycle latency.
  - Each actual value change pulses mode_change_pulse, increments change_count and zeros hold.
  - Windows still accumulate and last_density_milli still updates.
  - After release, the mode is retained and automatic evaluation resumes at the next window close.
- mode_eff_milli is combinational from current_mode: 0→1000, 1→600, 2→350, 3→200.
- util_milli_pct is ignored.
- Simultaneous reset and sample_valid: reset wins.

Test Plan:
- Reset, thresholds 700/400/150, hyst 50, min_hold 1; one window of 8 samples nz=80/tot=100 → window_complete pulse 1 cycle after 8th sample; density 800; mode 0; eff 1000; change_count 0.
- Following windows at densities 500, 300, 100, 850 → modes 1, 2, 3 (100<=150-50 boundary), 0; four mode_change_pulses; change_count=4; eff 600, 350, 200, 1000.
- Hysteresis: from mode 1, window density 680 (<700+50) → stays 1, no pulse; then 760 → mode 0.
- min_hold=3: density 300 immediately after a change → no change until the 3rd window since the change; change occurs on that window's close.
- Manual override=1, select=3 → current_mode=3 next cycle, one pulse, eff 200. Release, then density 900 window → mode 0.
- tot=0 for a whole window → density 1000. Reset asserted after 4 samples → next window needs 8 fresh samples; all outputs back to reset values.
